// File: rtl/exp_mul_axi4_lite_master_pkg.sv
// Shared constants and state types for the exp/mul AXI4-Lite command sequencer.
// Register offsets are relative to the slave base address.
package exp_mul_axi_pkg;

    localparam logic [31:0] OFS_A     = 32'h0000_0000;
    localparam logic [31:0] OFS_B     = 32'h0000_0004;
    localparam logic [31:0] OFS_SEL   = 32'h0000_0008;
    localparam logic [31:0] OFS_START = 32'h0000_000C;
    localparam logic [31:0] OFS_P     = 32'h0000_0010;
    localparam logic [31:0] OFS_DONE  = 32'h0000_0014;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_WR_SEL,
        ST_WR_START,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_RD_P,
        ST_RESP
    } seq_state_e;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_WRITE,
        XF_READ
    } xfer_state_e;

endpackage

// File: rtl/exp_mul_axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the command sequencer (master) and the
// exp/mul register slave.
interface exp_mul_axi_if;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic        M_AXI_BVALID;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic        M_AXI_RVALID;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
               M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
               M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
    );
endinterface

// File: rtl/exp_mul_axi4_lite_master_xfer.sv
// Single AXI4-Lite write or read handshake engine; done_o pulses for one cycle
// with the captured response (and read data for reads).
module axi_lite_single_xfer
    import exp_mul_axi_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          is_write_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic          done_o,
    output logic [31:0]   rdata_o,
    output logic [1:0]    resp_o,
    exp_mul_axi_if.master axi
);

    xfer_state_e state_q;
    logic        aw_done_q, w_done_q, done_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  resp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= XF_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            wstrb_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                XF_IDLE: begin
                    if (start_i && is_write_i) begin
                        state_q   <= XF_WRITE;
                        awaddr_q  <= addr_i;
                        wdata_q   <= wdata_i;
                        wstrb_q   <= 4'hF;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else if (start_i) begin
                        state_q   <= XF_READ;
                        araddr_q  <= addr_i;
                        arvalid_q <= 1'b1;
                    end
                end
                XF_WRITE: begin
                    // AW and W retire independently; B is only accepted once both have.
                    if (awvalid_q && axi.M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && axi.M_AXI_WREADY) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_q && w_done_q && !bready_q) begin
                        bready_q <= 1'b1;
                    end
                    if (bready_q && axi.M_AXI_BVALID) begin
                        bready_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        resp_q    <= axi.M_AXI_BRESP;
                        done_q    <= 1'b1;
                        state_q   <= XF_IDLE;
                    end
                end
                XF_READ: begin
                    if (arvalid_q && axi.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                    if (rready_q && axi.M_AXI_RVALID) begin
                        rready_q <= 1'b0;
                        rdata_q  <= axi.M_AXI_RDATA;
                        resp_q   <= axi.M_AXI_RRESP;
                        done_q   <= 1'b1;
                        state_q  <= XF_IDLE;
                    end
                end
                default: state_q <= XF_IDLE;
            endcase
        end
    end

    assign axi.M_AXI_AWADDR  = awaddr_q;
    assign axi.M_AXI_AWVALID = awvalid_q;
    assign axi.M_AXI_WDATA   = wdata_q;
    assign axi.M_AXI_WSTRB   = wstrb_q;
    assign axi.M_AXI_WVALID  = wvalid_q;
    assign axi.M_AXI_BREADY  = bready_q;
    assign axi.M_AXI_ARADDR  = araddr_q;
    assign axi.M_AXI_ARVALID = arvalid_q;
    assign axi.M_AXI_RREADY  = rready_q;
    assign done_o            = done_q;
    assign rdata_o           = rdata_q;
    assign resp_o            = resp_q;

endmodule

// File: rtl/exp_mul_axi4_lite_master.sv
// Command sequencer: programs A, B, SELECT, START, polls DONE, reads P.
// Optional DONE-poll timeout is built when EXPM_POLL_TIMEOUT_EN is defined.
module exp_mul_axi4_lite_master
    import exp_mul_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h7c80_0000,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned POLL_LIMIT = 1023
) (
    input  logic          M_AXI_ACLK,
    input  logic          M_AXI_ARESET,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_a,
    input  logic [31:0]   req_b,
    input  logic          req_sel,
    output logic          rsp_valid,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    exp_mul_axi_if.master m_axi
);

    localparam logic [7:0] GAP_LAST = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

    seq_state_e  state_q;
    logic        req_ready_q, rsp_valid_q, rsp_err_q, sel_q, err_q, issued_q;
    logic [31:0] a_q, b_q, rsp_data_q;
    logic [7:0]  gap_q;
`ifdef EXPM_POLL_TIMEOUT_EN
    logic [31:0] poll_cnt_q;
`endif

    logic        xfer_start_d, xfer_is_write_d, xfer_done;
    logic [31:0] xfer_addr_d, xfer_wdata_d, xfer_rdata;
    logic [1:0]  xfer_resp;

    // One transfer per transfer-owning state; issued_q stops a re-launch while it runs.
    always_comb begin
        xfer_start_d    = 1'b0;
        xfer_is_write_d = 1'b0;
        xfer_addr_d     = BASE_ADDR;
        xfer_wdata_d    = '0;
        unique case (state_q)
            ST_WR_A:     begin xfer_start_d = !issued_q; xfer_is_write_d = 1'b1;
                               xfer_addr_d = BASE_ADDR + OFS_A;     xfer_wdata_d = a_q; end
            ST_WR_B:     begin xfer_start_d = !issued_q; xfer_is_write_d = 1'b1;
                               xfer_addr_d = BASE_ADDR + OFS_B;     xfer_wdata_d = b_q; end
            ST_WR_SEL:   begin xfer_start_d = !issued_q; xfer_is_write_d = 1'b1;
                               xfer_addr_d = BASE_ADDR + OFS_SEL;   xfer_wdata_d = {31'b0, sel_q}; end
            ST_WR_START: begin xfer_start_d = !issued_q; xfer_is_write_d = 1'b1;
                               xfer_addr_d = BASE_ADDR + OFS_START; xfer_wdata_d = 32'd1; end
            ST_POLL_RD:  begin xfer_start_d = !issued_q; xfer_addr_d = BASE_ADDR + OFS_DONE; end
            ST_RD_P:     begin xfer_start_d = !issued_q; xfer_addr_d = BASE_ADDR + OFS_P; end
            default: ;
        endcase
    end

    axi_lite_single_xfer u_xfer (
        .clk_i      (M_AXI_ACLK),
        .rst_i      (M_AXI_ARESET),
        .start_i    (xfer_start_d),
        .is_write_i (xfer_is_write_d),
        .addr_i     (xfer_addr_d),
        .wdata_i    (xfer_wdata_d),
        .done_o     (xfer_done),
        .rdata_o    (xfer_rdata),
        .resp_o     (xfer_resp),
        .axi        (m_axi)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= 1'b0;
            err_q       <= 1'b0;
            issued_q    <= 1'b0;
            gap_q       <= '0;
`ifdef EXPM_POLL_TIMEOUT_EN
            poll_cnt_q  <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            if (xfer_start_d) issued_q <= 1'b1;
            // Error is sticky but never cuts the program short.
            if (xfer_done) begin
                issued_q <= 1'b0;
                if (xfer_resp != RESP_OKAY) err_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        sel_q       <= req_sel;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_WR_A;
`ifdef EXPM_POLL_TIMEOUT_EN
                        poll_cnt_q  <= '0;
`endif
                    end
                end
                ST_WR_A:     if (xfer_done) state_q <= ST_WR_B;
                ST_WR_B:     if (xfer_done) state_q <= ST_WR_SEL;
                ST_WR_SEL:   if (xfer_done) state_q <= ST_WR_START;
                ST_WR_START: if (xfer_done) state_q <= ST_POLL_RD;
                ST_POLL_RD: begin
                    if (xfer_done) begin
                        if (xfer_rdata[0]) begin
                            state_q <= ST_RD_P;
                        end
`ifdef EXPM_POLL_TIMEOUT_EN
                        else if (poll_cnt_q + 32'd1 == POLL_LIMIT) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                        end
`endif
                        else if (POLL_GAP == 0) begin
                            state_q <= ST_POLL_RD;
                        end else begin
                            state_q <= ST_POLL_WAIT;
                            gap_q   <= '0;
                        end
`ifdef EXPM_POLL_TIMEOUT_EN
                        poll_cnt_q <= poll_cnt_q + 32'd1;
`endif
                    end
                end
                ST_POLL_WAIT: begin
                    if (gap_q == GAP_LAST) state_q <= ST_POLL_RD;
                    else                   gap_q   <= gap_q + 8'd1;
                end
                ST_RD_P: begin
                    if (xfer_done) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= xfer_rdata;
                        rsp_err_q   <= err_q | (xfer_resp != RESP_OKAY);
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_exp_mul_axi4_lite_master.sv
// Bench for exp_mul_axi4_lite_master: behavioural register slave, protocol
// monitor, table vectors, reset/timeout sequences and randomized operations.
`timescale 1ns/1ps
module tb_exp_mul_axi4_lite_master;
    import exp_mul_axi_pkg::*;

    localparam logic [31:0] BASE = 32'h7c80_0000;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;
    localparam int GAP = 4;
`ifdef EXPM_POLL_TIMEOUT_EN
    localparam int LIMIT = 8;
`else
    localparam int LIMIT = 1023;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_sel = 1'b0;
    logic [31:0] req_a = '0, req_b = '0;
    logic req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_data;

    exp_mul_axi_if axi();

    exp_mul_axi4_lite_master #(.BASE_ADDR(BASE), .POLL_GAP(GAP), .POLL_LIMIT(LIMIT)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_sel(req_sel), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_axi(axi)
    );

    always #5 clk = ~clk;

    // Slave configuration, written only by the main test process.
    int aw_dly = 0, w_dly = 0, b_dly = 0, done_after = 1;
    logic [31:0] werr_addr = NONE, rerr_addr = NONE;

    // Behavioural register slave.
    logic aw_got = 0, w_got = 0, bvalid_r = 0, rvalid_r = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, polls = 0, aw_hs = 0, w_hs = 0;
    logic [31:0] aw_addr_l = 0, w_data_l = 0, reg_a = 0, reg_b = 0, reg_sel = 0, reg_p = 0, rdata_r = 0;
    logic [1:0] bresp_r = 0, rresp_r = 0;
    logic [63:0] wlog[$];
    logic [31:0] rlog[$];

    assign axi.M_AXI_AWREADY = !aw_got && (aw_wait >= aw_dly);
    assign axi.M_AXI_WREADY  = !w_got && (w_wait >= w_dly);
    assign axi.M_AXI_BVALID  = bvalid_r;
    assign axi.M_AXI_BRESP   = bresp_r;
    assign axi.M_AXI_ARREADY = !rvalid_r;
    assign axi.M_AXI_RVALID  = rvalid_r;
    assign axi.M_AXI_RDATA   = rdata_r;
    assign axi.M_AXI_RRESP   = rresp_r;

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 0; w_got <= 0; bvalid_r <= 0; rvalid_r <= 0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; polls <= 0;
        end else begin
            if (axi.M_AXI_AWVALID && !aw_got) begin
                if (axi.M_AXI_AWREADY) begin
                    aw_got <= 1; aw_addr_l <= axi.M_AXI_AWADDR; aw_hs <= aw_hs + 1;
                end else aw_wait <= aw_wait + 1;
            end
            if (axi.M_AXI_WVALID && !w_got) begin
                if (axi.M_AXI_WREADY) begin
                    w_got <= 1; w_data_l <= axi.M_AXI_WDATA; w_hs <= w_hs + 1;
                end else w_wait <= w_wait + 1;
            end
            if (aw_got && w_got && !bvalid_r) begin
                if (b_wait >= b_dly) begin
                    bvalid_r <= 1;
                    bresp_r  <= (aw_addr_l == werr_addr) ? 2'b10 : 2'b00;
                    wlog.push_back({aw_addr_l, w_data_l});
                    case (aw_addr_l - BASE)
                        32'h0: reg_a <= w_data_l;
                        32'h4: reg_b <= w_data_l;
                        32'h8: reg_sel <= w_data_l;
                        32'hC: begin
                            reg_p <= reg_sel[0] ? reg_a ** reg_b : reg_a * reg_b;
                            polls <= 0;
                        end
                        default: ;
                    endcase
                end else b_wait <= b_wait + 1;
            end
            if (bvalid_r && axi.M_AXI_BREADY) begin
                bvalid_r <= 0; aw_got <= 0; w_got <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0;
            end
            if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
                rvalid_r <= 1;
                rlog.push_back(axi.M_AXI_ARADDR);
                rresp_r <= (axi.M_AXI_ARADDR == rerr_addr) ? 2'b10 : 2'b00;
                if (axi.M_AXI_ARADDR == BASE + 32'h14) begin
                    polls   <= polls + 1;
                    rdata_r <= {31'b0, (done_after != 0) && (polls + 1 >= done_after)};
                end else if (axi.M_AXI_ARADDR == BASE + 32'h10) rdata_r <= reg_p;
                else rdata_r <= 32'd0;
            end
            if (rvalid_r && axi.M_AXI_RREADY) rvalid_r <= 0;
        end
    end

    // Protocol monitor: stable VALID payloads, one outstanding transaction, B after AW+W.
    logic p_awv = 0, p_wv = 0, p_arv = 0, p_awr = 0, p_wr = 0, p_arr = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
    int viol = 0, cyc = 0;
    int done_rises[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            p_awv <= 0; p_wv <= 0; p_arv <= 0;
        end else begin
            viol <= viol + $countones({
                p_awv && !p_awr && (!axi.M_AXI_AWVALID || axi.M_AXI_AWADDR != p_awaddr),
                p_wv && !p_wr && (!axi.M_AXI_WVALID || axi.M_AXI_WDATA != p_wdata),
                p_arv && !p_arr && (!axi.M_AXI_ARVALID || axi.M_AXI_ARADDR != p_araddr),
                axi.M_AXI_WVALID && axi.M_AXI_WSTRB != 4'hF,
                (axi.M_AXI_AWVALID || axi.M_AXI_WVALID) && axi.M_AXI_ARVALID,
                (aw_got || w_got || axi.M_AXI_AWVALID) && (axi.M_AXI_ARVALID || axi.M_AXI_RREADY),
                axi.M_AXI_BREADY && !(aw_got && w_got)});
            if (axi.M_AXI_ARVALID && !p_arv && axi.M_AXI_ARADDR == BASE + 32'h14)
                done_rises.push_back(cyc);
            p_awv <= axi.M_AXI_AWVALID; p_wv <= axi.M_AXI_WVALID; p_arv <= axi.M_AXI_ARVALID;
        end
        p_awr <= axi.M_AXI_AWREADY; p_wr <= axi.M_AXI_WREADY; p_arr <= axi.M_AXI_ARREADY;
        p_awaddr <= axi.M_AXI_AWADDR; p_wdata <= axi.M_AXI_WDATA; p_araddr <= axi.M_AXI_ARADDR;
    end

    // Response monitor.
    int rsp_cnt = 0, rsp_dbl = 0;
    logic prev_rv = 0, last_err = 0;
    logic [31:0] last_data = 0;
    always @(negedge clk) begin
        if (rst) prev_rv <= 0;
        else begin
            if (rsp_valid) begin
                rsp_cnt <= rsp_cnt + 1; last_data <= rsp_data; last_err <= rsp_err;
            end
            if (rsp_valid && prev_rv) rsp_dbl <= rsp_dbl + 1;
            prev_rv <= rsp_valid;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference result: plain repeated multiplication modulo 2^32.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic sel);
        logic [31:0] r;
        if (!sel) return a * b;
        r = 32'd1;
        for (int i = 0; i < int'(b); i++) r = r * a;
        return r;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sel,
                          output logic ok, output logic [31:0] data, output logic err);
        int c0 = rsp_cnt;
        int n = 0;
        ok = 1'b0; data = '0; err = 1'b0;
        @(negedge clk);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (rsp_cnt == c0 && n < 3000) begin @(negedge clk); #1; n++; end
        if (rsp_cnt == c0) check("rsp_timeout", 0, 1);
        else begin ok = 1'b1; data = last_data; err = last_err; end
        repeat (3) @(negedge clk);
        check("rsp_count", 64'(rsp_cnt - c0), 1);
    endtask

    typedef struct {
        logic [31:0] a, b; logic sel; int aw_d, w_d;
        logic [31:0] werr, rerr; int done_n; logic [31:0] exp_data; logic exp_err;
    } vec_t;

    task automatic apply(input vec_t v, input string tag);
        int w0 = wlog.size(), r0 = rlog.size(), aw0 = aw_hs, w0h = w_hs, v0 = viol;
        int bad = 0, nr;
        logic ok, err;
        logic [31:0] data, ea;
        logic [63:0] ew [4];
        aw_dly = v.aw_d; w_dly = v.w_d; werr_addr = v.werr; rerr_addr = v.rerr; done_after = v.done_n;
        run_op(v.a, v.b, v.sel, ok, data, err);
        if (!ok) return;
        check({tag, "_data"}, data, v.exp_data);
        check({tag, "_err"}, err, v.exp_err);
        check({tag, "_aw_hs"}, 64'(aw_hs - aw0), 4);
        check({tag, "_w_hs"}, 64'(w_hs - w0h), 4);
        ew[0] = {BASE, v.a}; ew[1] = {BASE + 32'h4, v.b};
        ew[2] = {BASE + 32'h8, {31'b0, v.sel}}; ew[3] = {BASE + 32'hC, 32'd1};
        check({tag, "_nwrites"}, 64'(wlog.size() - w0), 4);
        for (int i = 0; i < 4 && w0 + i < wlog.size(); i++) if (wlog[w0 + i] !== ew[i]) bad++;
        check({tag, "_write_seq"}, 64'(bad), 0);
        nr = (v.done_n == 0) ? LIMIT : v.done_n + 1;
        check({tag, "_nreads"}, 64'(rlog.size() - r0), 64'(nr));
        bad = 0;
        for (int i = 0; i < nr && r0 + i < rlog.size(); i++) begin
            ea = (v.done_n != 0 && i == nr - 1) ? BASE + 32'h10 : BASE + 32'h14;
            if (rlog[r0 + i] !== ea) bad++;
        end
        check({tag, "_read_seq"}, 64'(bad), 0);
        check({tag, "_protocol"}, 64'(viol - v0), 0);
    endtask

    vec_t vecs[12];

    initial begin
        logic ok, err;
        logic [31:0] data, a, b;
        logic sel;
        int g0, n;
        vec_t rv;

        vecs[0]  = '{32'd2, 32'd3, 1'b0, 0, 0, NONE, NONE, 3, 32'd6, 1'b0};
        vecs[1]  = '{32'd2, 32'd3, 1'b1, 3, 0, NONE, NONE, 1, 32'd8, 1'b0};
        vecs[2]  = '{32'd2, 32'd3, 1'b1, 0, 3, NONE, NONE, 1, 32'd8, 1'b0};
        vecs[3]  = '{32'd2, 32'd3, 1'b1, 0, 0, BASE + 32'h8, NONE, 2, 32'd8, 1'b1};
        vecs[4]  = '{32'd7, 32'd5, 1'b0, 2, 2, NONE, NONE, 1, 32'd35, 1'b0};
        vecs[5]  = '{32'd3, 32'd4, 1'b1, 1, 2, BASE, NONE, 1, 32'd81, 1'b1};
        vecs[6]  = '{32'hFFFF_FFFF, 32'd2, 1'b0, 0, 0, NONE, NONE, 2, 32'hFFFF_FFFE, 1'b0};
        vecs[7]  = '{32'd2, 32'd31, 1'b1, 0, 0, NONE, NONE, 1, 32'h8000_0000, 1'b0};
        vecs[8]  = '{32'd2, 32'd32, 1'b1, 0, 1, NONE, NONE, 1, 32'd0, 1'b0};
        vecs[9]  = '{32'd0, 32'd0, 1'b1, 0, 0, BASE + 32'hC, NONE, 1, 32'd1, 1'b1};
        vecs[10] = '{32'd5, 32'd6, 1'b0, 0, 0, NONE, BASE + 32'h10, 1, 32'd30, 1'b1};
        vecs[11] = '{32'd9, 32'd9, 1'b0, 0, 0, NONE, BASE + 32'h14, 2, 32'd81, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                             axi.M_AXI_ARVALID, axi.M_AXI_RREADY, rsp_valid}, 0);
        check("rst_addr_data", {axi.M_AXI_AWADDR, axi.M_AXI_WDATA}, 0);
        check("rst_wstrb_rsp", {axi.M_AXI_WSTRB, rsp_err, rsp_data}, 0);

        // Table vectors; the first one also measures the DONE poll spacing.
        g0 = done_rises.size();
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                check("poll_rises", 64'(done_rises.size() - g0), 3);
                // Spacing = gap cycles + AR beat + R beat + done + relaunch.
                for (int k = g0 + 1; k < done_rises.size() && k < g0 + 3; k++)
                    check("poll_spacing", 64'(done_rises[k] - done_rises[k - 1]), 64'(GAP + 4));
            end
        end
        check("rsp_single_cycle", 64'(rsp_dbl), 0);

        // Reset while the B write waits for BVALID.
        b_dly = 30; aw_dly = 0; w_dly = 0; werr_addr = NONE; rerr_addr = NONE; done_after = 1;
        g0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'd4; req_b = 32'd5; req_sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(axi.M_AXI_BREADY && axi.M_AXI_AWADDR == BASE + 32'h4) && n < 300) begin
            @(negedge clk); n++;
        end
        check("reset_reach_b_wait", axi.M_AXI_BREADY, 1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                               axi.M_AXI_ARVALID, axi.M_AXI_RREADY, rsp_valid}, 0);
        check("reset_req_ready", req_ready, 1);
        rst = 1'b0;
        b_dly = 0;
        repeat (10) @(negedge clk);
        check("reset_no_rsp", 64'(rsp_cnt - g0), 0);
        apply('{32'd4, 32'd5, 1'b1, 0, 0, NONE, NONE, 2, 32'd1024, 1'b0}, "after_reset");

`ifdef EXPM_POLL_TIMEOUT_EN
        apply('{32'd6, 32'd7, 1'b0, 0, 0, NONE, NONE, 0, 32'd0, 1'b1}, "timeout");
`endif

        // Randomized operations against the reference result.
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom_range(0, 1));
            a = $urandom;
            b = sel ? 32'($urandom_range(0, 12)) : $urandom;
            rv.a = a; rv.b = b; rv.sel = sel;
            rv.aw_d = $urandom_range(0, 3); rv.w_d = $urandom_range(0, 3);
            rv.werr = ($urandom_range(0, 4) == 0) ? BASE + 32'($urandom_range(0, 3)) * 4 : NONE;
            rv.rerr = ($urandom_range(0, 5) == 0) ? BASE + 32'h10 : NONE;
            rv.done_n = $urandom_range(1, 3);
            rv.exp_data = ref_result(a, b, sel);
            rv.exp_err = (rv.werr != NONE) || (rv.rerr != NONE);
            b_dly = $urandom_range(0, 2);
            apply(rv, $sformatf("rand%0d", i));
        end
        check("final_rsp_single_cycle", 64'(rsp_dbl), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
